// File: rtl/uart_tx_pkg.sv
// ============================================================================
// uart_tx_pkg -- shared types and register-map constants for uart_tx_io, rev 1.0
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [1:0] UART_DATA = 2'd0;
  localparam logic [1:0] UART_DIV  = 2'd2;
  localparam logic [1:0] UART_CLR  = 2'd3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;

endpackage

`default_nettype wire

// File: rtl/uart_tx_io_fifo.sv
// ============================================================================
// tx_fifo -- 8-bit synchronous FIFO with extra-MSB pointers, rev 1.0
// ============================================================================
`default_nettype none

module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // When full, a simultaneous pop frees the slot the push is about to reuse.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_io.sv
// ============================================================================
// uart_tx_io -- IO-bus UART transmitter: bus decode, FIFO, 8N1 serialiser, rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_io
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd199
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IOWrite,
  input  logic        IORead,
  input  logic        UARTCtrl,
  input  logic [1:0]  uart_addr,
  input  logic [31:0] uart_wdata,
  output logic [31:0] uart_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  tx_state_e   state_q, state_d;
  logic [15:0] divisor_q, divisor_d;
  logic [15:0] div_q, div_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        overflow_q, overflow_d;

  logic        wr_en, rd_en, push, pop, bit_end;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;
  logic        unused_wdata;

  assign unused_wdata = ^uart_wdata[31:16];

  assign wr_en   = IOWrite & UARTCtrl;
  assign rd_en   = IORead & UARTCtrl;
  assign push    = wr_en && (uart_addr == UART_DATA);
  assign bit_end = (timer_q == div_q);
  assign tx_busy = (state_q != ST_IDLE);

  tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clock),
    .rst_ni (reset),
    .push_i (push),
    .din_i  (uart_wdata[7:0]),
    .pop_i  (pop),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    divisor_d  = divisor_q;
    overflow_d = overflow_q;
    if (wr_en && (uart_addr == UART_DIV)) divisor_d = uart_wdata[15:0];
    // A dropped push outranks a clear so an overflow is never silently lost.
    if (push && fifo_full && !pop)                overflow_d = 1'b1;
    else if (wr_en && (uart_addr == UART_CLR))    overflow_d = 1'b0;
  end

  always_comb begin
    uart_rdata = 32'd0;
    if (rd_en) begin
      case (uart_addr)
        UART_DATA: uart_rdata = {28'd0, overflow_q, fifo_full, fifo_empty, tx_busy};
        UART_DIV:  uart_rdata = {16'd0, divisor_q};
        default:   uart_rdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    timer_d = timer_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    uart_tx = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          div_d   = divisor_q;
          timer_d = 16'd0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        uart_tx = 1'b0;
        if (bit_end) begin
          timer_d = 16'd0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_DATA: begin
        uart_tx = shift_q[0];
        if (bit_end) begin
          timer_d = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          timer_d = 16'd0;
          // Chain straight into the next start bit so queued frames abut.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            div_d   = divisor_q;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      divisor_q  <= DIV_RESET;
      div_q      <= DIV_RESET;
      timer_q    <= 16'd0;
      shift_q    <= 8'd0;
      bit_q      <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      divisor_q  <= divisor_d;
      div_q      <= div_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_io.sv
// ============================================================================
// tb_uart_tx_io -- randomized self-checking bench for uart_tx_io, rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_io;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        IOWrite = 1'b0, IORead = 1'b0, UARTCtrl = 1'b0;
  logic [1:0]  uart_addr = 2'd0;
  logic [31:0] uart_wdata = 32'd0;
  logic [31:0] uart_rdata;
  logic        uart_tx, tx_busy;

  int checks = 0;
  int errors = 0;

  int cur_div = 199;
  int epoch = 0;
  logic [7:0] rx_q[$];

  int run_cnt = 0, last_run = 0, runs_done = 0;

  uart_tx_io #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd199)) dut (
    .clock     (clock),
    .reset     (reset),
    .IOWrite   (IOWrite),
    .IORead    (IORead),
    .UARTCtrl  (UARTCtrl),
    .uart_addr (uart_addr),
    .uart_wdata(uart_wdata),
    .uart_rdata(uart_rdata),
    .uart_tx   (uart_tx),
    .tx_busy   (tx_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks are entered and left at a falling clock edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic cs);
    IOWrite = 1'b1; UARTCtrl = cs; uart_addr = a; uart_wdata = d;
    @(negedge clock);
    IOWrite = 1'b0; UARTCtrl = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic cs, output logic [31:0] d);
    IORead = 1'b1; UARTCtrl = cs; uart_addr = a;
    #1 d = uart_rdata;
    IORead = 1'b0; UARTCtrl = 1'b0;
  endtask

  task automatic wait_run(input int snap, input int budget);
    int n = 0;
    while (runs_done == snap && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("run_timeout", 32'(runs_done != snap), 32'd1);
  endtask

  always @(negedge clock) begin
    if (tx_busy) run_cnt <= run_cnt + 1;
    else if (run_cnt != 0) begin
      last_run  <= run_cnt;
      run_cnt   <= 0;
      runs_done <= runs_done + 1;
    end
  end

  // Line monitor: sample each bit in its first cycle using the divisor in force at the start bit.
  initial begin
    forever begin
      int f, ep;
      logic [7:0] b;
      @(negedge uart_tx);
      ep = epoch;
      f  = cur_div + 1;
      @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        repeat (f) @(negedge clock);
        b[i] = uart_tx;
      end
      repeat (f) @(negedge clock);
      if (ep == epoch) begin
        check("stop_bit", 32'(uart_tx), 32'd1);
        rx_q.push_back(b);
      end
    end
  end

  // Occupancy/frame-period model of a burst of k pushes on consecutive edges from idle.
  task automatic burst(input int d, input int k);
    int f10, occ, nxt, snap;
    bit busy, ovf, pop;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [31:0] r;
    wr(2'd2, 32'(d), 1'b1);
    cur_div = d;
    @(negedge clock);
    rx_q.delete();
    snap = runs_done;
    f10 = 10 * (d + 1);
    occ = 0; nxt = 0; busy = 0; ovf = 0;
    for (int e = 1; e <= k; e++) begin
      b = 8'($urandom);
      IOWrite = 1'b1; UARTCtrl = 1'b1; uart_addr = 2'd0; uart_wdata = {24'd0, b};
      pop = 0;
      if (!busy) begin
        if (occ > 0) begin pop = 1; busy = 1; nxt = e + f10; end
      end else if (e == nxt) begin
        if (occ > 0) begin pop = 1; nxt = e + f10; end
        else busy = 0;
      end
      if (occ == DEPTH && !pop) ovf = 1;
      else begin exp_q.push_back(b); occ++; end
      if (pop) occ--;
      @(negedge clock);
    end
    IOWrite = 1'b0; UARTCtrl = 1'b0;
    rd(2'd0, 1'b1, r);
    check("burst_status", r, {28'd0, ovf, 1'(occ == DEPTH), 1'(occ == 0), busy});
    wait_run(snap, exp_q.size() * f10 + 50);
    check("burst_len", 32'(last_run), 32'(exp_q.size() * f10));
    repeat (3) @(negedge clock);
    check("burst_rx_n", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check("burst_rx", 32'(rx_q[i]), 32'(exp_q[i]));
    if (ovf) wr(2'd3, 32'($urandom), 1'b1);
    rd(2'd0, 1'b1, r);
    check("burst_clr", r, 32'h2);
  endtask

  initial begin
    logic [31:0] r;
    logic [9:0]  frame;
    int snap;

    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_rdata", uart_rdata, 32'd0);
    rd(2'd0, 1'b1, r); check("rst_status", r, 32'h2);
    rd(2'd2, 1'b1, r); check("rst_div", r, 32'd199);

    // Directed 0xA5 at divisor 3: frame is start, LSB-first data, stop.
    wr(2'd2, 32'd3, 1'b1);
    cur_div = 3;
    rx_q.delete();
    snap = runs_done;
    frame = {1'b1, 8'hA5, 1'b0};
    wr(2'd0, 32'hA5, 1'b1);
    @(negedge clock);
    for (int i = 0; i < 40; i++) begin
      check("a5_line", 32'(uart_tx), 32'(frame[i / 4]));
      if (i == 0 || i == 39) check("a5_busy", 32'(tx_busy), 32'd1);
      @(negedge clock);
    end
    check("a5_idle", 32'(tx_busy), 32'd0);
    wait_run(snap, 20);
    check("a5_len", 32'(last_run), 32'd40);
    check("a5_rx_n", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("a5_rx", 32'(rx_q[0]), 32'hA5);

    // Divisor change mid-frame only affects the following frame.
    rx_q.delete();
    snap = runs_done;
    wr(2'd0, 32'h11, 1'b1);
    wr(2'd0, 32'hE7, 1'b1);
    repeat (10) @(negedge clock);
    wr(2'd2, 32'd7, 1'b1);
    cur_div = 7;
    wait_run(snap, 200);
    check("divchg_len", 32'(last_run), 32'd120);
    repeat (3) @(negedge clock);
    check("divchg_rx_n", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      check("divchg_rx0", 32'(rx_q[0]), 32'h11);
      check("divchg_rx1", 32'(rx_q[1]), 32'hE7);
    end
    rd(2'd2, 1'b1, r); check("divchg_div", r, 32'd7);

    // Ten pushes at divisor 0 overrun the 8-deep FIFO by one.
    burst(0, 10);
    for (int t = 0; t < 6; t++) burst($urandom_range(0, 3), $urandom_range(1, 12));

    // Deselected and offset-1 accesses leave state untouched and read zero.
    wr(2'd2, 32'd55, 1'b0);
    wr(2'd0, 32'h5A, 1'b0);
    wr(2'd1, 32'hFFFF_FFFF, 1'b1);
    repeat (3) @(negedge clock);
    check("nocs_busy", 32'(tx_busy), 32'd0);
    rd(2'd2, 1'b0, r); check("nocs_rd", r, 32'd0);
    rd(2'd1, 1'b1, r); check("off1_rd", r, 32'd0);
    rd(2'd2, 1'b1, r); check("nocs_div", r, 32'(cur_div));
    rd(2'd0, 1'b1, r); check("nocs_status", r, 32'h2);

    // Asynchronous reset in the middle of the data bits.
    wr(2'd2, 32'd3, 1'b1);
    cur_div = 3;
    wr(2'd0, 32'h3C, 1'b1);
    wr(2'd0, 32'hC3, 1'b1);
    repeat (12) @(negedge clock);
    check("mid_busy", 32'(tx_busy), 32'd1);
    #3 reset = 1'b0;
    epoch++;
    #1;
    check("arst_tx", 32'(uart_tx), 32'd1);
    check("arst_busy", 32'(tx_busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    cur_div = 199;
    repeat (50) @(negedge clock);
    check("post_busy", 32'(tx_busy), 32'd0);
    rd(2'd0, 1'b1, r); check("post_status", r, 32'h2);
    rd(2'd2, 1'b1, r); check("post_div", r, 32'd199);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
